// File: rtl/timer_ctrl_if.sv
// Counter-side bus between timer_ctrl (master) and one up/down loadable counter (slave).
interface timer_ctrl_if #(
  parameter int unsigned W = 32
);
  logic [W-1:0] cnt_q;
  logic         cnt_rc;
  logic         cnt_s;
  logic         cnt_load;
  logic [W-1:0] cnt_pdata;

  modport master (
    input  cnt_q, cnt_rc,
    output cnt_s, cnt_load, cnt_pdata
  );

  modport slave (
    output cnt_q, cnt_rc,
    input  cnt_s, cnt_load, cnt_pdata
  );
endinterface

// File: rtl/timer_ctrl.sv
// One-shot / periodic timer sequencer driving a free-running up/down loadable counter
// through its load/pdata/dir inputs, with prescaler and sticky irq/ovf.
module timer_ctrl #(
  parameter int unsigned W     = 32,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_period,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_mode,
  input  logic             cfg_dir,
  input  logic             start,
  input  logic             stop,
  input  logic             irq_ack,
  timer_ctrl_if.master     cnt,
  output logic             busy,
  output logic             irq,
  output logic             ovf
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_dly_q, tick_dly_d;
  logic [W-1:0]     period_q, period_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic             mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;

  logic             tick_c;
  logic             expire_c;
  logic [W-1:0]     start_val_c;
  logic [W-1:0]     term_val_c;
  logic             cnt_load_c;
  logic [W-1:0]     cnt_pdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pre_q      <= '0;
      tick_dly_q <= 1'b0;
      period_q   <= '0;
      prescale_q <= '0;
      mode_q     <= 1'b0;
      dir_q      <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      tick_dly_q <= tick_dly_d;
      period_q   <= period_d;
      prescale_q <= prescale_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  // Up-counting starts from ~P so both directions expire after P+1 steps.
  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    tick_dly_d  = 1'b0;
    period_d    = period_q;
    prescale_d  = prescale_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    irq_d       = irq_q;
    ovf_d       = ovf_q;
    cnt_load_c  = 1'b1;
    cnt_pdata_c = cnt.cnt_q;

    tick_c      = (pre_q == prescale_q);
    start_val_c = dir_q ? ~period_q : period_q;
    term_val_c  = {W{dir_q}};
    // tick_dly is 0 in LOAD and after freezes, so a stale cnt_rc cannot fire.
    expire_c    = (state_q == ST_RUN) && tick_dly_q && cnt.cnt_rc;

    if (irq_ack) begin
      irq_d = 1'b0;
      ovf_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          period_d   = cfg_period;
          prescale_d = cfg_prescale;
          mode_d     = cfg_mode;
          dir_d      = cfg_dir;
        end
        if (start && !stop) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_pdata_c = start_val_c;
        pre_d       = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        tick_dly_d = tick_c;
        if (tick_c) begin
          cnt_load_c = 1'b0;
          pre_d      = '0;
        end else begin
          pre_d = PRE_W'(pre_q + 1'b1);
        end
        if (expire_c) begin
          irq_d      = 1'b1;
          if (irq_q) ovf_d = 1'b1;
          cnt_load_c = 1'b1;
          if (mode_q) begin
            cnt_pdata_c = start_val_c;
            pre_d       = '0;
            tick_dly_d  = 1'b0;
          end else begin
            cnt_pdata_c = term_val_c;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Stop beats start; both only act while the timer is active.
    if (state_q != ST_IDLE) begin
      if (stop) begin
        cnt_load_c  = 1'b1;
        cnt_pdata_c = cnt.cnt_q;
        state_d     = ST_IDLE;
      end else if (start) begin
        state_d = ST_LOAD;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign cnt.cnt_s     = dir_q;
  assign cnt.cnt_load  = cnt_load_c;
  assign cnt.cnt_pdata = cnt_pdata_c;
  assign busy          = busy_q;
  assign irq           = irq_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with a behavioural model of the up/down loadable counter.
module tb_timer_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_prescale = '0;
  logic        cfg_mode = 1'b0;
  logic        cfg_dir = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        irq_ack = 1'b0;
  logic        busy, irq, ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  timer_ctrl_if #(.W(32)) u_if ();

  timer_ctrl #(.W(32), .PRE_W(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_period   (cfg_period),
    .cfg_prescale (cfg_prescale),
    .cfg_mode     (cfg_mode),
    .cfg_dir      (cfg_dir),
    .start        (start),
    .stop         (stop),
    .irq_ack      (irq_ack),
    .cnt          (u_if.master),
    .busy         (busy),
    .irq          (irq),
    .ovf          (ovf)
  );

  // Counter model: no reset, no enable, rc only updated on stepping edges.
  logic [31:0] m_q = 32'h1234_5678;
  logic        m_rc = 1'b0;
  always @(posedge clk) begin
    if (u_if.cnt_load) begin
      m_q <= u_if.cnt_pdata;
    end else begin
      m_q  <= u_if.cnt_s ? m_q + 32'd1 : m_q - 32'd1;
      m_rc <= u_if.cnt_s ? (m_q == 32'hFFFF_FFFF) : (m_q == 32'h0);
    end
  end
  assign u_if.cnt_q  = m_q;
  assign u_if.cnt_rc = m_rc;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic configure(input logic [31:0] p, input logic [7:0] n, input logic mode, input logic dir);
    cfg_we = 1'b1; cfg_period = p; cfg_prescale = n; cfg_mode = mode; cfg_dir = dir;
    irq_ack = 1'b1;
    step();
    cfg_we = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    // Reset state: counter frozen while reset is held
    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_cnt_s", u_if.cnt_s, 0);
    check_eq("rst_load", u_if.cnt_load, 1);
    check_eq("rst_pdata", u_if.cnt_pdata, 32'h1234_5678);
    step(); step();
    rst_n = 1'b1;
    step();
    check_eq("rst_cnt_hold", m_q, 32'h1234_5678);

    // 1: down one-shot P=3 N=0
    configure(32'd3, 8'd0, 1'b0, 1'b0);
    do_start();
    check_eq("t1_busy_L", busy, 1);
    check_eq("t1_load_L", u_if.cnt_load, 1);
    check_eq("t1_pdata_L", u_if.cnt_pdata, 32'd3);
    run_to(1); check_eq("t1_q1", m_q, 32'd3);
    run_to(2); check_eq("t1_q2", m_q, 32'd2);
    run_to(3); check_eq("t1_q3", m_q, 32'd1);
    run_to(4); check_eq("t1_q4", m_q, 32'd0);
    run_to(5); check_eq("t1_q5", m_q, 32'hFFFF_FFFF);
    check_eq("t1_irq_E", irq, 0);
    run_to(6);
    check_eq("t1_irq", irq, 1);
    check_eq("t1_busy", busy, 0);
    check_eq("t1_q6", m_q, 32'd0);
    run_to(9); check_eq("t1_q_hold", m_q, 32'd0);

    // 2: up periodic P=9 N=1, expiries 21 apart, ovf after unacked re-expiry
    configure(32'd9, 8'd1, 1'b1, 1'b1);
    check_eq("t2_irq_acked", irq, 0);
    do_start();
    check_eq("t2_cnt_s", u_if.cnt_s, 1);
    run_to(1);  check_eq("t2_q1", m_q, 32'hFFFF_FFF6);
    run_to(20); check_eq("t2_load20", u_if.cnt_load, 0);
    run_to(21);
    check_eq("t2_load21", u_if.cnt_load, 1);
    check_eq("t2_pdata21", u_if.cnt_pdata, 32'hFFFF_FFF6);
    check_eq("t2_q21", m_q, 32'd0);
    run_to(22);
    check_eq("t2_irq22", irq, 1);
    check_eq("t2_q22", m_q, 32'hFFFF_FFF6);
    run_to(25);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_eq("t2_irq_ack", irq, 0);
    check_eq("t2_ovf_ack", ovf, 0);
    run_to(41); check_eq("t2_load41", u_if.cnt_load, 0);
    run_to(42);
    check_eq("t2_load42", u_if.cnt_load, 1);
    check_eq("t2_pdata42", u_if.cnt_pdata, 32'hFFFF_FFF6);
    run_to(43);
    check_eq("t2_irq43", irq, 1);
    check_eq("t2_ovf43", ovf, 0);
    run_to(64);
    check_eq("t2_irq64", irq, 1);
    check_eq("t2_ovf64", ovf, 1);
    do_stop();
    check_eq("t2_busy_stop", busy, 0);

    // 3: stop at L+2 of down P=100 run, then restart reloads
    configure(32'd100, 8'd0, 1'b0, 1'b0);
    do_start();
    run_to(2);
    stop = 1'b1;
    #1;
    check_eq("t3_load_stop", u_if.cnt_load, 1);
    check_eq("t3_pdata_stop", u_if.cnt_pdata, 32'd99);
    step();
    stop = 1'b0;
    check_eq("t3_busy", busy, 0);
    check_eq("t3_q_stop", m_q, 32'd99);
    run_to(13);
    check_eq("t3_q_hold", m_q, 32'd99);
    check_eq("t3_busy_hold", busy, 0);
    do_start();
    run_to(1); check_eq("t3_reload", m_q, 32'd100);
    do_stop();

    // 4: irq_ack coinciding with expiry, periodic P=2 N=0
    configure(32'd2, 8'd0, 1'b1, 1'b0);
    do_start();
    run_to(4);
    check_eq("t4_load4", u_if.cnt_load, 1);
    check_eq("t4_pdata4", u_if.cnt_pdata, 32'd2);
    check_eq("t4_q4", m_q, 32'hFFFF_FFFF);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_eq("t4_irq5", irq, 1);
    check_eq("t4_ovf5", ovf, 0);
    check_eq("t4_q5", m_q, 32'd2);
    run_to(8);
    check_eq("t4_load8", u_if.cnt_load, 1);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    check_eq("t4_irq9", irq, 1);
    check_eq("t4_ovf9", ovf, 1);
    do_stop();
    check_eq("t4_irq_after_stop", irq, 1);

    // 5: async reset mid-run
    configure(32'd50, 8'd0, 1'b0, 1'b0);
    do_start();
    run_to(5);
    check_eq("t5_q5", m_q, 32'd46);
    rst_n = 1'b0;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_irq", irq, 0);
    check_eq("t5_load", u_if.cnt_load, 1);
    check_eq("t5_pdata", u_if.cnt_pdata, 32'd46);
    step(); step(); step();
    check_eq("t5_q_rst", m_q, 32'd46);
    rst_n = 1'b1;
    step();
    check_eq("t5_q_after", m_q, 32'd46);
    check_eq("t5_busy_after", busy, 0);

    // 6: cfg_we during RUN is ignored
    configure(32'd50, 8'd0, 1'b0, 1'b0);
    do_start();
    run_to(2);
    cfg_we = 1'b1; cfg_period = 32'd5;
    step();
    cfg_we = 1'b0;
    run_to(8);
    check_eq("t6_busy8", busy, 1);
    check_eq("t6_irq8", irq, 0);
    run_to(51);
    check_eq("t6_irq51", irq, 0);
    check_eq("t6_q51", m_q, 32'd0);
    run_to(52);
    check_eq("t6_load52", u_if.cnt_load, 1);
    check_eq("t6_pdata52", u_if.cnt_pdata, 32'd0);
    check_eq("t6_q52", m_q, 32'hFFFF_FFFF);
    run_to(53);
    check_eq("t6_irq53", irq, 1);
    check_eq("t6_busy53", busy, 0);
    do_start();
    run_to(1); check_eq("t6_reload", m_q, 32'd50);
    do_stop();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the 32-bit up/down loadable counter. It turns the free-running counter into a programmable one-shot or periodic timer with a prescaler, direction select and a sticky interrupt. It does this purely by driving the counter's direction, load and parallel-data inputs and by watching its count and terminal flag. It sits between the CPU-side configuration and control strobes and a single counter instance.

## Interface
- `W`, default 32: counter width; fixed at 32.
- `PRE_W`, default 8: prescaler width.

- `clk`  in  1  rising-edge clock, shared with the counter
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  write `cfg_period`/`cfg_prescale`/`cfg_mode`/`cfg_dir`; accepted only while idle
- `cfg_period`  in  32  P: terminal count
- `cfg_prescale`  in  PRE_W  N: one counter step every N+1 clocks
- `cfg_mode`  in  1  0 = one-shot, 1 = periodic
- `cfg_dir`  in  1  0 = down, 1 = up
- `start`  in  1  (re)start pulse
- `stop`  in  1  stop pulse
- `irq_ack`  in  1  clears `irq` and `ovf`
- `cnt_q`  in  32  counter value
- `cnt_rc`  in  1  counter registered terminal flag
- `cnt_s`  out  1  counter direction; equals the registered dir
- `cnt_load`  out  1  counter load (combinational)
- `cnt_pdata`  out  32  counter parallel data (combinational)
- `busy`  out  1  state is LOAD or RUN
- `irq`  out  1  sticky expiry flag
- `ovf`  out  1  sticky "expired while `irq` already set"

## Operation
- Counter model:
  - The counter has no reset and no enable, and steps every clock unless load is high.
  - `cnt_rc` is updated only on non-load edges.
  - `cnt_rc` goes to 1 on the edge that steps the counter away from 0 (down) or from all-ones (up).
- Freeze: whenever the counter must not move, drive `cnt_load` = 1 and `cnt_pdata` = `cnt_q`.
- Start value S:
  - Down: S = P.
  - Up: S = ~P.
  - Either way, expiry occurs after P+1 steps.
- Terminal value T: 0 for down, 0xFFFFFFFF for up.
- States: IDLE, LOAD, RUN.
- IDLE:
  - Freeze.
  - `cfg_we` updates the config registers.
  - `start` moves to LOAD.
- LOAD (one cycle):
  - `cnt_load` = 1, `cnt_pdata` = S.
  - Prescaler count `pre` := 0 and `tick_d` := 0.
  - Next state is RUN.
- RUN:
  - tick = (`pre` == N). On tick, `pre` := 0; otherwise `pre` := `pre` + 1.
  - On tick cycles, `cnt_load` = 0 and the counter steps. On non-tick cycles, freeze.
  - `tick_d` is tick registered.
- Expiry: in RUN with `tick_d` & `cnt_rc`.
  - This overrides the tick: `cnt_load` = 1.
  - Periodic: `cnt_pdata` = S, `pre` := 0, `tick_d` := 0, stay in RUN. The expiry cycle acts as the reload.
  - One-shot: `cnt_pdata` = T, next state is IDLE.
  - `irq` := 1. If `irq` was already 1, `ovf` := 1.
- A stale `cnt_rc` = 1 held through LOAD or freeze cycles is never treated as expiry, because `tick_d` = 0 in those cycles.
- `stop` in LOAD or RUN: freeze this cycle, next state is IDLE, count retained.
- `start` in LOAD or RUN: restart, going to LOAD next cycle.
- `start` and `stop` in the same cycle: `stop` wins.
- `cfg_we` in LOAD or RUN: ignored entirely.
- `irq_ack` in the same cycle as an expiry: the set wins, so `irq` = 1. `ovf` follows the pre-ack `irq`.
- Stopping or restarting does not clear `irq`.

## Timing
- Reset (async, `rst_n` = 0):
  - State IDLE.
  - `irq` = `ovf` = `busy` = 0 and `cnt_s` = 0.
  - Config registers, `pre` and `tick_d` all 0.
  - `cnt_load` = 1 and `cnt_pdata` = `cnt_q`, so the counter freezes while reset is asserted.
- Reset mid-run: immediate return to IDLE; counter value retained.
- Start timing: `start` sampled at edge e puts LOAD in cycle e+1; call that cycle L.
- Ticks fall at cycles L + k(N+1), for k = 1..P+1.
- Expiry cycle E = L + (P+1)(N+1) + 1.
- `irq` is high from E+1.
- One-shot end of run: `busy` low from E+1, and `cnt_q` = T in E+1.
- Periodic interval between expiries: (P+1)(N+1) + 1 clocks.
- `busy`, `irq`, `ovf` and `cnt_s` are registered. `cnt_load` and `cnt_pdata` are combinational from state, `pre`, `tick_d`, `cnt_rc` and `cnt_q`.
- Wrap-around: P = 0xFFFFFFFF is legal. The counter passes through the full 2^32 range without any special case.

## Test plan
1. Down, one-shot, P=3, N=0:
   - `start` → LOAD at L, `cnt_q` sequence 3,2,1,0,FFFFFFFF.
   - `irq` high at L+6, `busy` low at L+6, `cnt_q` = 0 held.
2. Up, periodic, P=9, N=1:
   - `cnt_q` = FFFFFFF6 after each reload.
   - Expiries exactly 21 clocks apart, `irq` set at the first.
   - Ack then re-set with no ack gives `ovf` = 1.
3. `stop` at L+2 of a down P=100 run:
   - `cnt_q` constant for 10 cycles, `busy` = 0.
   - A later `start` reloads 100.
4. `irq_ack` coinciding with an expiry in periodic P=2, N=0:
   - `irq` stays 1.
   - `ovf` = 1 only if `irq` was 1 beforehand.
5. `rst_n` pulled low mid-RUN:
   - Same cycle: `busy` = `irq` = 0 and `cnt_load` = 1.
   - `cnt_q` unchanged through and after reset.
6. `cfg_we` with P=5 during a RUN with P=50:
   - The current run still expires at P=50 timing.
   - The next `start` still uses P=50.
